ibuf_vc: RTL and testbench

IBUF_VC -- requirements
Module: ibuf_vc

---
 rtl/ibuf_vc.sv | 123 ++++++++++++
 tb/tb_ibuf_vc.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ibuf_vc.sv
// rtl/ibuf_vc.sv - per-VC input flit buffer: circular FIFO with packet count and sticky error flags
`ifndef DATAW
`define DATAW 15
`endif
`ifndef TYPE_MSB
`define TYPE_MSB 15
`endif
`ifndef TYPE_LSB
`define TYPE_LSB 13
`endif
`ifndef TYPE_NONE
`define TYPE_NONE 3'd0
`endif
`ifndef TYPE_HEAD
`define TYPE_HEAD 3'd1
`endif
`ifndef TYPE_DATA
`define TYPE_DATA 3'd2
`endif
`ifndef TYPE_TAIL
`define TYPE_TAIL 3'd3
`endif
`ifndef TYPE_HEADTAIL
`define TYPE_HEADTAIL 3'd4
`endif

module ibuf_vc #(
  parameter int DEPTH    = 4,
  parameter int ROUTERID = 0,
  parameter int PCHID    = 0,
  parameter int VCHID    = 0
) (
  input  logic                         clk,
  input  logic                         rst_,
  input  logic [`DATAW:0]              idata,
  input  logic                         iwe,
  output logic                         ordy,
  input  logic                         ore,
  output logic [`DATAW:0]              bdata,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       count,
  output logic [$clog2(DEPTH):0]       npkt,
  output logic                         ovf,
  output logic                         udf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = `TYPE_MSB - `TYPE_LSB + 1;

  // Identity parameters only travel with the instance; reject nonsense values at elaboration.
  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 ||
      ROUTERID < 0 || PCHID < 0 || VCHID < 0) begin : g_param_check
    $error("ibuf_vc: illegal parameter value");
  end

  function automatic logic is_end(input logic [TW-1:0] t);
    return (t == `TYPE_TAIL) || (t == `TYPE_HEADTAIL);
  endfunction

  logic [`DATAW:0] r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_npkt;
  logic            r_ovf;
  logic            r_udf;

  logic            w_full;
  logic            w_empty;
  logic            w_wr;
  logic            w_rd;
  logic            w_wr_end;
  logic            w_rd_end;
  logic [`DATAW:0] w_head;

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_wr     = iwe && !w_full;
  assign w_rd     = ore && !w_empty;
  assign w_head   = w_empty ? {`TYPE_NONE, {`TYPE_LSB{1'b0}}} : r_mem[r_rptr];
  assign w_wr_end = w_wr && is_end(idata[`TYPE_MSB:`TYPE_LSB]);
  assign w_rd_end = w_rd && is_end(w_head[`TYPE_MSB:`TYPE_LSB]);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= idata;
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_npkt  <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_rd) r_rptr <= r_rptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      case ({w_wr_end, w_rd_end})
        2'b10:   r_npkt <= r_npkt + CW'(1);
        2'b01:   r_npkt <= r_npkt - CW'(1);
        default: r_npkt <= r_npkt;
      endcase
      if (iwe && w_full)  r_ovf <= 1'b1;
      if (ore && w_empty) r_udf <= 1'b1;
    end
  end

  assign ordy  = !w_full;
  assign empty = w_empty;
  assign bdata = w_head;
  assign count = r_count;
  assign npkt  = r_npkt;
  assign ovf   = r_ovf;
  assign udf   = r_udf;

endmodule

// File: tb/tb_ibuf_vc.sv
// tb/tb_ibuf_vc.sv - self-checking bench for ibuf_vc against a queue-based reference model
`ifndef DATAW
`define DATAW 15
`endif
`ifndef TYPE_MSB
`define TYPE_MSB 15
`endif
`ifndef TYPE_LSB
`define TYPE_LSB 13
`endif
`ifndef TYPE_NONE
`define TYPE_NONE 3'd0
`endif
`ifndef TYPE_HEAD
`define TYPE_HEAD 3'd1
`endif
`ifndef TYPE_DATA
`define TYPE_DATA 3'd2
`endif
`ifndef TYPE_TAIL
`define TYPE_TAIL 3'd3
`endif
`ifndef TYPE_HEADTAIL
`define TYPE_HEADTAIL 3'd4
`endif

module tb_ibuf_vc;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_ = 1'b1;
  logic [`DATAW:0]   idata = '0;
  logic              iwe = 1'b0;
  logic              ore = 1'b0;
  logic              ordy;
  logic [`DATAW:0]   bdata;
  logic              empty;
  logic [CW-1:0]     count;
  logic [CW-1:0]     npkt;
  logic              ovf;
  logic              udf;

  int checks = 0;
  int errors = 0;

  ibuf_vc #(.DEPTH(DEPTH), .ROUTERID(1), .PCHID(2), .VCHID(3)) dut (
    .clk(clk), .rst_(rst_), .idata(idata), .iwe(iwe), .ordy(ordy), .ore(ore),
    .bdata(bdata), .empty(empty), .count(count), .npkt(npkt), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of flits plus sticky flags.
  logic [`DATAW:0] m_q[$];
  bit m_ovf = 0, m_udf = 0, m_valid = 0;

  function automatic bit is_end(input logic [`DATAW:0] f);
    return (f[`TYPE_MSB:`TYPE_LSB] == `TYPE_TAIL) || (f[`TYPE_MSB:`TYPE_LSB] == `TYPE_HEADTAIL);
  endfunction

  function automatic int m_npkt();
    int n = 0;
    foreach (m_q[i]) if (is_end(m_q[i])) n++;
    return n;
  endfunction

  always @(posedge clk) begin
    if (rst_) begin
      m_q.delete();
      m_ovf = 0;
      m_udf = 0;
      m_valid = 1;
    end else if (m_valid) begin
      bit full, emp;
      full = (m_q.size() == DEPTH);
      emp  = (m_q.size() == 0);
      if (iwe && full) m_ovf = 1;
      if (ore && emp)  m_udf = 1;
      if (ore && !emp) void'(m_q.pop_front());
      if (iwe && !full) m_q.push_back(idata);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      logic [`DATAW:0] eh;
      eh = (m_q.size() > 0) ? m_q[0] : '0;
      chk("model_count", 32'(count), 32'(m_q.size()));
      chk("model_npkt",  32'(npkt),  32'(m_npkt()));
      chk("model_empty", 32'(empty), 32'(m_q.size() == 0));
      chk("model_ordy",  32'(ordy),  32'(m_q.size() < DEPTH));
      chk("model_ovf",   32'(ovf),   32'(m_ovf));
      chk("model_udf",   32'(udf),   32'(m_udf));
      chk("model_bdata", 32'(bdata), 32'(eh));
    end
  end

  function automatic logic [`DATAW:0] mk(input logic [2:0] t, input logic [12:0] p);
    return {t, p};
  endfunction

  // Apply one cycle of inputs; return after the following falling edge.
  task automatic cyc(input bit r, input bit w, input bit rd, input logic [`DATAW:0] d);
    rst_ = r; iwe = w; ore = rd; idata = d;
    @(posedge clk);
    @(negedge clk);
    rst_ = 0; iwe = 0; ore = 0; idata = '0;
  endtask

  logic [2:0] exp_types [4] = '{`TYPE_HEAD, `TYPE_DATA, `TYPE_DATA, `TYPE_TAIL};

  initial begin
    cyc(1, 0, 0, '0);
    cyc(1, 1, 1, mk(`TYPE_HEAD, 13'h1));
    chk("rst_count", 32'(count), 0);
    chk("rst_ordy",  32'(ordy), 1);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_bdata", 32'(bdata), 0);

    // Fill with one packet.
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, mk(exp_types[i], 13'(16'h10 + i)));
    chk("fill_count", 32'(count), 4);
    chk("fill_ordy",  32'(ordy), 0);
    chk("fill_npkt",  32'(npkt), 1);
    chk("fill_head",  32'(bdata[`TYPE_MSB:`TYPE_LSB]), 32'(`TYPE_HEAD));

    // Overflow write is dropped.
    cyc(0, 1, 0, mk(`TYPE_HEADTAIL, 13'h55));
    chk("ovf_flag",  32'(ovf), 1);
    chk("ovf_count", 32'(count), 4);

    for (int i = 0; i < 4; i++) begin
      chk("drain_type", 32'(bdata[`TYPE_MSB:`TYPE_LSB]), 32'(exp_types[i]));
      chk("drain_pay",  32'(bdata[12:0]), 32'(16'h10 + i));
      cyc(0, 0, 1, '0);
    end
    chk("drain_empty", 32'(empty), 1);
    chk("drain_npkt",  32'(npkt), 0);
    chk("drain_type_none", 32'(bdata[`TYPE_MSB:`TYPE_LSB]), 32'(`TYPE_NONE));

    // Steady stream at count=2 across pointer wraps.
    cyc(1, 0, 0, '0);
    cyc(0, 1, 0, mk(`TYPE_HEAD, 13'h100));
    cyc(0, 1, 0, mk(`TYPE_DATA, 13'h101));
    for (int i = 0; i < 10; i++) begin
      chk("stream_order", 32'(bdata[12:0]), 32'(16'h100 + i));
      cyc(0, 1, 1, mk((i == 9) ? `TYPE_TAIL : `TYPE_DATA, 13'(16'h102 + i)));
    end
    chk("stream_count", 32'(count), 2);
    chk("stream_npkt",  32'(npkt), 1);

    // Simultaneous read/write on empty buffer.
    cyc(1, 0, 0, '0);
    cyc(0, 1, 1, mk(`TYPE_HEADTAIL, 13'h77));
    chk("udf_flag",  32'(udf), 1);
    chk("udf_count", 32'(count), 1);
    chk("udf_npkt",  32'(npkt), 1);
    chk("udf_bdata", 32'(bdata), 32'(mk(`TYPE_HEADTAIL, 13'h77)));
    cyc(0, 0, 1, '0);
    chk("ht_read_npkt", 32'(npkt), 0);

    // Simultaneous read/write on full buffer.
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, mk(exp_types[i], 13'(16'h200 + i)));
    cyc(0, 1, 1, mk(`TYPE_HEAD, 13'h2ff));
    chk("full_rw_ovf",   32'(ovf), 1);
    chk("full_rw_count", 32'(count), 3);
    chk("full_rw_head",  32'(bdata), 32'(mk(`TYPE_DATA, 13'h201)));

    // Mid-packet reset with count=3 and both error flags set.
    cyc(1, 1, 1, mk(`TYPE_DATA, 13'h3));
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_empty", 32'(empty), 1);
    chk("mid_rst_ordy",  32'(ordy), 1);
    chk("mid_rst_ovf",   32'(ovf), 0);
    chk("mid_rst_udf",   32'(udf), 0);
    chk("mid_rst_bdata", 32'(bdata), 0);

    cyc(0, 1, 0, mk(`TYPE_HEAD, 13'h9));
    chk("post_rst_head", 32'(bdata), 32'(mk(`TYPE_HEAD, 13'h9)));
    cyc(0, 0, 0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
